// File: rtl/serial_sub8_if.sv
// Handshake and data bundle between a controller (master) and the serial subtractor (slave).
interface serial_sub8_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;

  modport master (
    output start, a, b, bin,
    input  ready, done, diff, bout, overflow
  );

  modport slave (
    input  start, a, b, bin,
    output ready, done, diff, bout, overflow
  );
endinterface

// File: rtl/serial_sub8.sv
// Bit-serial two's-complement subtractor, diff = a - b - bin, one bit per clock, LSB first.
// Optional SERIAL_SUB_SATURATE_EN clamps diff to the signed range when overflow is flagged.
module serial_sub8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub8_if.slave sub
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             bitD;
  logic             brNext;
  logic [WIDTH-1:0] rawDiff;

  // Single full-subtractor cell; on the last bit br_q is the borrow into the MSB.
  assign bitD    = opA_q[0] ^ opB_q[0] ^ br_q;
  assign brNext  = (~opA_q[0] & opB_q[0]) | (~(opA_q[0] ^ opB_q[0]) & br_q);
  assign rawDiff = {bitD, res_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (sub.start) begin
          opA_d   = sub.a;
          opB_d   = sub.b;
          br_d    = sub.bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        opA_d = opA_q >> 1;
        opB_d = opB_q >> 1;
        br_d  = brNext;
        res_d = rawDiff[WIDTH-1:1];
        cnt_d = cnt_q + CNT_W'(1);
        // Results are published only on the final bit so outputs stay frozen mid-op.
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          diff_d  = rawDiff;
          bout_d  = brNext;
          ovf_d   = br_q ^ brNext;
`ifdef SERIAL_SUB_SATURATE_EN
          if (br_q ^ brNext) begin
            diff_d = opA_q[0] ? SAT_MIN : SAT_MAX;
          end
`else
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sub.ready    = (state_q != SHIFT);
  assign sub.done     = (state_q == DONE);
  assign sub.diff     = diff_q;
  assign sub.bout     = bout_q;
  assign sub.overflow = ovf_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Self-checking bench for serial_sub8: directed table, control corner cases and random ops vs. an arithmetic model.
module tb_serial_sub8;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_sub8_if #(.WIDTH(WIDTH)) subIf ();

  serial_sub8 #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sub  (subIf)
  );

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] expDiff;
    logic       expBout;
    logic       expOvf;
  } vector_t;

  vector_t vectors[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: true integer subtraction, then wrap / range-test the result.
  function automatic void refModel(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                   output logic [7:0] d, output logic bo, output logic ov);
    int ud;
    int sd;
    ud = int'(a) - int'(b) - int'(bin);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = ud[7:0];
    bo = (ud < 0);
    ov = (sd > 127) || (sd < -128);
`ifdef SERIAL_SUB_SATURATE_EN
    if (ov) d = (sd > 127) ? 8'h7F : 8'h80;
`endif
  endfunction

  // Called at a negedge with ready=1; returns at the negedge right after the accept edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin);
    subIf.a     = a;
    subIf.b     = b;
    subIf.bin   = bin;
    subIf.start = 1'b1;
    @(negedge clk);
    subIf.start = 1'b0;
  endtask

  task automatic waitDone(input int startLat, output int lat, output bit stable);
    logic [7:0] heldDiff;
    logic       heldBout;
    logic       heldOvf;
    heldDiff = subIf.diff;
    heldBout = subIf.bout;
    heldOvf  = subIf.overflow;
    lat      = startLat;
    stable   = 1'b1;
    while (subIf.done !== 1'b1 && lat <= 20) begin
      if (subIf.diff !== heldDiff || subIf.bout !== heldBout || subIf.overflow !== heldOvf)
        stable = 1'b0;
      subIf.a   = 8'($urandom);
      subIf.b   = 8'($urandom);
      subIf.bin = 1'($urandom);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] expDiff, input logic expBout, input logic expOvf);
    int lat;
    bit stable;
    applyStimulus(a, b, bin);
    waitDone(0, lat, stable);
    checkOutput({name, " latency"}, lat, 8);
    checkOutput({name, " diff"}, subIf.diff, expDiff);
    checkOutput({name, " bout"}, subIf.bout, expBout);
    checkOutput({name, " overflow"}, subIf.overflow, expOvf);
    checkOutput({name, " ready"}, subIf.ready, 1);
    checkOutput({name, " held"}, stable, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] negOvfDiff;
    logic [7:0] posOvfDiff;
    logic [7:0] ra, rb, rd;
    logic       rbin, rbo, rov;
    int lat;
    int doneSeen;
    bit stable;

`ifdef SERIAL_SUB_SATURATE_EN
    negOvfDiff = 8'h80;
    posOvfDiff = 8'h7F;
`else
    negOvfDiff = 8'h7F;
    posOvfDiff = 8'h80;
`endif
    vectors[0] = '{8'h05, 8'h03, 1'b0, 8'h02,       1'b0, 1'b0};
    vectors[1] = '{8'h00, 8'h01, 1'b0, 8'hFF,       1'b1, 1'b0};
    vectors[2] = '{8'h10, 8'h10, 1'b1, 8'hFF,       1'b1, 1'b0};
    vectors[3] = '{8'h80, 8'h01, 1'b0, negOvfDiff,  1'b0, 1'b1};
    vectors[4] = '{8'h7F, 8'hFF, 1'b0, posOvfDiff,  1'b1, 1'b1};
    vectors[5] = '{8'h00, 8'h00, 1'b0, 8'h00,       1'b0, 1'b0};
    vectors[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF,       1'b1, 1'b0};

    subIf.start = 1'b0;
    subIf.a     = 8'h00;
    subIf.b     = 8'h00;
    subIf.bin   = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset ready", subIf.ready, 1);
    checkOutput("reset done", subIf.done, 0);
    checkOutput("reset diff", subIf.diff, 0);
    checkOutput("reset bout", subIf.bout, 0);
    checkOutput("reset overflow", subIf.overflow, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle ready", subIf.ready, 1);
    checkOutput("idle done", subIf.done, 0);

    for (int i = 0; i < 7; i++) begin
      runOp($sformatf("vec%0d", i), vectors[i].a, vectors[i].b, vectors[i].bin,
            vectors[i].expDiff, vectors[i].expBout, vectors[i].expOvf);
      @(negedge clk);
    end

    // start pulsed mid-SHIFT must be ignored
    applyStimulus(8'h33, 8'h11, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("midshift ready", subIf.ready, 0);
    subIf.a     = 8'hFF;
    subIf.b     = 8'h00;
    subIf.start = 1'b1;
    @(negedge clk);
    subIf.start = 1'b0;
    waitDone(3, lat, stable);
    checkOutput("midshift latency", lat, 8);
    checkOutput("midshift diff", subIf.diff, 8'h22);
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (subIf.done === 1'b1) doneSeen++;
    end
    checkOutput("midshift extra done", doneSeen, 0);

    // back-to-back: start held in the DONE cycle
    applyStimulus(8'h40, 8'h01, 1'b0);
    waitDone(0, lat, stable);
    checkOutput("b2b first latency", lat, 8);
    checkOutput("b2b first diff", subIf.diff, 8'h3F);
    applyStimulus(8'h20, 8'h30, 1'b0);
    waitDone(1, lat, stable);
    checkOutput("b2b second gap", lat, 9);
    checkOutput("b2b second diff", subIf.diff, 8'hF0);
    checkOutput("b2b second bout", subIf.bout, 1);
    checkOutput("b2b first held", stable, 1);

    // reset during SHIFT aborts the op
    @(negedge clk);
    applyStimulus(8'h09, 8'h02, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort ready", subIf.ready, 1);
    checkOutput("abort done", subIf.done, 0);
    checkOutput("abort diff", subIf.diff, 0);
    checkOutput("abort bout", subIf.bout, 0);
    checkOutput("abort overflow", subIf.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (subIf.done === 1'b1) doneSeen++;
    end
    checkOutput("abort no done", doneSeen, 0);

    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      refModel(ra, rb, rbin, rd, rbo, rov);
      runOp($sformatf("rand%0d", i), ra, rb, rbin, rd, rbo, rov);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
